// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: 11-bit frames, E0/F0 prefix tracking, event FIFO.
// Optional ps2_clk glitch filter enabled by defining PS2_GLITCH_FILTER_EN.
module ps2_scan_receiver #(
    parameter int SYNC_STAGES    = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       evt_valid,
    input  logic       evt_ready,
    input  logic       err_clr,
    output logic       parity_err,
    output logic       frame_err,
    output logic       timeout_err,
    output logic       overflow_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_PAR  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   w_clk_s;
    logic                   w_dat_s;
    logic                   w_clk_f;
    logic                   r_clk_prev;
    logic                   w_fall;
    logic                   r_fall;
    logic [1:0]             r_state;
    logic [7:0]             r_shift;
    logic [2:0]             r_bit_cnt;
    logic                   r_par_ok;
    logic                   r_done;
    logic [TW-1:0]          r_to_cnt;
    logic                   w_to_hit;
    logic                   r_ext_pend;
    logic                   r_brk_pend;
    logic                   w_push;
    logic [9:0]             r_mem [FIFO_DEPTH];
    logic [AW:0]            r_wr;
    logic [AW:0]            r_rd;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_wr_en;
    logic                   w_par_set;
    logic                   w_frm_set;
    logic                   w_ovf_set;

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

    // Synchronise both pins; idle bus level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

`ifdef PS2_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN) + 1;
    logic [FW-1:0] r_flt_cnt;
    logic          r_flt_lvl;

    assign w_clk_f = r_flt_lvl;

    // Accept a new clock level only after FILTER_LEN equal samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flt_cnt <= '0;
            r_flt_lvl <= 1'b1;
        end else if (w_clk_s == r_flt_lvl) begin
            r_flt_cnt <= '0;
        end else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
            r_flt_cnt <= '0;
            r_flt_lvl <= w_clk_s;
        end else begin
            r_flt_cnt <= r_flt_cnt + 1'b1;
        end
    end
`else
    localparam int w_unused_filter_len = FILTER_LEN;
    assign w_clk_f = w_clk_s;
`endif

    assign w_fall = r_clk_prev & ~w_clk_f;

    // Detect the falling edge, then sample one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_prev <= 1'b1;
            r_fall     <= 1'b0;
        end else begin
            r_clk_prev <= w_clk_f;
            r_fall     <= w_fall;
        end
    end

    assign w_to_hit = (r_state != S_IDLE)
                   && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Idle-gap counter for abandoning partial frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_fall || r_state == S_IDLE || w_to_hit) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Frame FSM: start, 8 data bits LSB first, odd parity, stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par_ok  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_to_hit) begin
                r_state <= S_IDLE;
            end else if (r_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_dat_s) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shift   <= {w_dat_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) r_state <= S_PAR;
                    end
                    S_PAR: begin
                        r_par_ok <= (^r_shift) ^ w_dat_s;
                        r_state  <= S_STOP;
                    end
                    default: begin
                        r_done  <= w_dat_s & r_par_ok;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign w_push = r_done && (r_shift != 8'hE0) && (r_shift != 8'hF0);

    // Track E0/F0 prefixes for the next real scan code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (w_to_hit) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (r_done) begin
            if (r_shift == 8'hE0) begin
                r_ext_pend <= 1'b1;
            end else if (r_shift == 8'hF0) begin
                r_brk_pend <= 1'b1;
            end else begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end
        end
    end

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[AW] != r_rd[AW])
                  && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = !w_empty && evt_ready;
    assign w_wr_en = w_push && (!w_full || w_pop);

    // Event FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr[AW-1:0]] <= {r_shift, r_ext_pend, r_brk_pend};
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
        end
    end

    assign evt_valid = !w_empty;
    assign {evt_code, evt_ext, evt_break} = r_mem[r_rd[AW-1:0]];

    assign w_frm_set = r_fall && !w_to_hit
                    && ((r_state == S_IDLE && w_dat_s)
                     || (r_state == S_STOP && !w_dat_s));
    assign w_par_set = r_fall && !w_to_hit
                    && (r_state == S_STOP) && !r_par_ok;
    assign w_ovf_set = w_push && w_full && !w_pop;

    // Sticky error flags; a clear wins over a same-cycle set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            timeout_err  <= 1'b0;
            overflow_err <= 1'b0;
        end else if (err_clr) begin
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            timeout_err  <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (w_par_set) parity_err   <= 1'b1;
            if (w_frm_set) frame_err    <= 1'b1;
            if (w_to_hit)  timeout_err  <= 1'b1;
            if (w_ovf_set) overflow_err <= 1'b1;
        end
    end
endmodule
